idli_serial_alu_m: RTL and testbench

Parametrised bit-serial ALU/compare unit for the idli execute stage. It consumes one SLICE_W-bit slice of each operand per cycle, LSB first, under the shared sync counter, and returns a registered result slice per cycle. It carries state across slices (carry, shift-out, zero/sign accumulation) and produces compare flags after the final slice. It is driven by the decode outputs (alu_op, alu_inv, alu_cin, cmp_op) and register-file operand slices.

---
 rtl/idli_pkg.sv | 42 ++++
 rtl/idli_alu_slice_m.sv | 51 +++++
 rtl/idli_serial_alu_m.sv | 143 ++++++++++++++
 tb/tb_idli_serial_alu_m.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli execute stage.
// Holds the ALU/compare opcode encodings and the flag-to-compare mapping.
package idli_pkg;

  localparam int unsigned ALU_SLICE_W_DEFAULT = 4;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluAnd = 3'd1,
    AluOr  = 3'd2,
    AluXor = 3'd3,
    AluShl = 3'd4
  } alu_op_t;

  typedef enum logic [2:0] {
    CmpNone = 3'd0,
    CmpEq   = 3'd1,
    CmpNe   = 3'd2,
    CmpLt   = 3'd3,
    CmpLtu  = 3'd4,
    CmpGe   = 3'd5,
    CmpGeu  = 3'd6
  } cmp_op_t;

  // Flags come from lhs-rhs: cout=1 means no borrow (lhs >= rhs unsigned).
  function automatic logic cmp_eval(input cmp_op_t op, input logic zero, input logic n,
                                    input logic v, input logic cout);
    logic r;
    r = 1'b0;
    case (op)
      CmpEq:   r = zero;
      CmpNe:   r = ~zero;
      CmpLt:   r = n ^ v;
      CmpLtu:  r = ~cout;
      CmpGe:   r = ~(n ^ v);
      CmpGeu:  r = cout;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idli_alu_slice_m.sv
// Combinational SLICE_W-bit ALU slice; carry-in doubles as the shift-in bit for SHL.
// msb_cin is the carry into the top bit, used for signed overflow on the final slice.
module idli_alu_slice_m
  import idli_pkg::*;
#(
  parameter int unsigned SLICE_W = ALU_SLICE_W_DEFAULT
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  alu_op_t            op,
  input  logic               inv,
  input  logic               cin,
  output logic [SLICE_W-1:0] res,
  output logic               cout,
  output logic               msb_cin
);

  logic [SLICE_W-1:0] b_eff;
  logic [SLICE_W:0]   sum;
  logic [SLICE_W:0]   shl;

  assign b_eff = inv ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE_W{1'b0}}, cin};
  // Concatenation keeps the shift well-formed even for 1-bit slices.
  assign shl   = {a, cin};

  assign msb_cin = a[SLICE_W-1] ^ b_eff[SLICE_W-1] ^ sum[SLICE_W-1];

  always_comb begin
    res  = '0;
    cout = 1'b0;
    case (op)
      AluAdd: begin
        res  = sum[SLICE_W-1:0];
        cout = sum[SLICE_W];
      end
      AluAnd: res = a & b_eff;
      AluOr:  res = a | b_eff;
      AluXor: res = a ^ b_eff;
      AluShl: begin
        res  = shl[SLICE_W-1:0];
        cout = shl[SLICE_W];
      end
      default: begin
        res  = '0;
        cout = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/idli_serial_alu_m.sv
// Bit-serial ALU/compare unit: one operand slice per cycle, LSB first, under the sync counter.
// Registers the result slice each cycle and pulses compare flags after the final slice.
module idli_serial_alu_m
  import idli_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned SLICE_W = ALU_SLICE_W_DEFAULT,
  localparam int unsigned NSLICE = DATA_W / SLICE_W,
  localparam int unsigned CTR_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic               i_alu_gck,
  input  logic               i_alu_rst_n,
  input  logic [CTR_W-1:0]   i_alu_ctr,
  input  logic               i_alu_vld,
  input  alu_op_t            i_alu_op,
  input  logic               i_alu_inv,
  input  logic               i_alu_cin,
  input  cmp_op_t            i_alu_cmp_op,
  input  logic [SLICE_W-1:0] i_alu_lhs,
  input  logic [SLICE_W-1:0] i_alu_rhs,
  output logic [SLICE_W-1:0] o_alu_res,
  output logic               o_alu_res_vld,
  output logic               o_alu_cout,
  output logic               o_alu_cmp,
  output logic               o_alu_cmp_vld
);

  localparam logic [0:0]       StIdle  = 1'b0;
  localparam logic [0:0]       StBusy  = 1'b1;
  localparam logic [CTR_W-1:0] LastIdx = CTR_W'(NSLICE - 1);

  logic [0:0]       state_q, state_d;
  logic [CTR_W-1:0] idx_q;
  alu_op_t          op_q;
  logic             inv_q;
  cmp_op_t          cmp_op_q;
  logic             carry_q;
  logic             zero_q;

  logic [SLICE_W-1:0] res_q;
  logic               res_vld_q;
  logic               cout_q;
  logic               cmp_q;
  logic               cmp_vld_q;

  logic    acc_cont, acc_start, accept, last;
  alu_op_t start_op, cur_op;
  logic    start_inv, start_cin, cur_inv, cur_cin;
  cmp_op_t cur_cmp;
  logic    zero_acc, flag_n, flag_v;

  logic [SLICE_W-1:0] slice_res;
  logic               slice_cout;
  logic               slice_msb_cin;

  always_comb begin
    acc_cont  = (state_q == StBusy) && i_alu_vld && (i_alu_ctr == idx_q);
    // A slice-0 arriving out of sequence restarts rather than merely aborting.
    acc_start = i_alu_vld && (i_alu_ctr == '0) && !acc_cont;
    accept    = acc_cont | acc_start;
    last      = accept && (i_alu_ctr == LastIdx);

    // Compares always run lhs-rhs, whatever the decoded op says.
    if (i_alu_cmp_op != CmpNone) begin
      start_op  = AluAdd;
      start_inv = 1'b1;
      start_cin = 1'b1;
    end else begin
      start_op  = i_alu_op;
      start_inv = i_alu_inv;
      start_cin = (i_alu_op == AluShl) ? 1'b0 : i_alu_cin;
    end

    cur_op  = acc_start ? start_op     : op_q;
    cur_inv = acc_start ? start_inv    : inv_q;
    cur_cin = acc_start ? start_cin    : carry_q;
    cur_cmp = acc_start ? i_alu_cmp_op : cmp_op_q;

    state_d = (accept && !last) ? StBusy : StIdle;
  end

  idli_alu_slice_m #(
    .SLICE_W (SLICE_W)
  ) u_slice (
    .a       (i_alu_lhs),
    .b       (i_alu_rhs),
    .op      (cur_op),
    .inv     (cur_inv),
    .cin     (cur_cin),
    .res     (slice_res),
    .cout    (slice_cout),
    .msb_cin (slice_msb_cin)
  );

  always_comb begin
    zero_acc = (acc_start | zero_q) & ~(|slice_res);
    flag_n   = slice_res[SLICE_W-1];
    flag_v   = slice_msb_cin ^ slice_cout;
  end

  always_ff @(posedge i_alu_gck or negedge i_alu_rst_n) begin
    if (!i_alu_rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      op_q      <= AluAdd;
      inv_q     <= 1'b0;
      cmp_op_q  <= CmpNone;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      cout_q    <= 1'b0;
      cmp_q     <= 1'b0;
      cmp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_vld_q <= accept;
      cmp_vld_q <= last;
      if (accept) begin
        res_q   <= slice_res;
        carry_q <= slice_cout;
        zero_q  <= zero_acc;
        idx_q   <= i_alu_ctr + 1'b1;
      end
      if (acc_start) begin
        op_q     <= start_op;
        inv_q    <= start_inv;
        cmp_op_q <= i_alu_cmp_op;
      end
      if (last) begin
        cout_q <= slice_cout;
        cmp_q  <= cmp_eval(cur_cmp, zero_acc, flag_n, flag_v, slice_cout);
      end
    end
  end

  assign o_alu_res     = res_q;
  assign o_alu_res_vld = res_vld_q;
  assign o_alu_cout    = cout_q;
  assign o_alu_cmp     = cmp_q;
  assign o_alu_cmp_vld = cmp_vld_q;

endmodule

// File: tb/tb_idli_serial_alu_m.sv
// Bench for idli_serial_alu_m: a 16-bit/4-bit-slice instance and an 8-bit/1-bit-slice instance,
// directed vector table, corner sequences and randomized ops against a word-level model.
module tb_idli_serial_alu_m;
  import idli_pkg::*;

  typedef struct {
    alu_op_t     op;
    logic        inv;
    logic        cin;
    cmp_op_t     cmp;
    logic [15:0] lhs;
    logic [15:0] rhs;
    logic [15:0] eres;
    logic        ecout;
    logic        ecmp;
  } vec_t;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        cmp;
  } out_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic    rst_n16, rst_n8;
  alu_op_t d_op;
  logic    d_inv, d_cin;
  cmp_op_t d_cmp;

  logic [1:0] ctr16;
  logic       vld16;
  logic [3:0] lhs16, rhs16, res16;
  logic       res_vld16, cout16, cmp16, cmp_vld16;

  logic [2:0] ctr8;
  logic       vld8;
  logic [0:0] lhs8, rhs8, res8;
  logic       res_vld8, cout8, cmp8, cmp_vld8;

  idli_serial_alu_m #(.DATA_W(16), .SLICE_W(4)) u_dut16 (
    .i_alu_gck    (clk),
    .i_alu_rst_n  (rst_n16),
    .i_alu_ctr    (ctr16),
    .i_alu_vld    (vld16),
    .i_alu_op     (d_op),
    .i_alu_inv    (d_inv),
    .i_alu_cin    (d_cin),
    .i_alu_cmp_op (d_cmp),
    .i_alu_lhs    (lhs16),
    .i_alu_rhs    (rhs16),
    .o_alu_res    (res16),
    .o_alu_res_vld(res_vld16),
    .o_alu_cout   (cout16),
    .o_alu_cmp    (cmp16),
    .o_alu_cmp_vld(cmp_vld16)
  );

  idli_serial_alu_m #(.DATA_W(8), .SLICE_W(1)) u_dut8 (
    .i_alu_gck    (clk),
    .i_alu_rst_n  (rst_n8),
    .i_alu_ctr    (ctr8),
    .i_alu_vld    (vld8),
    .i_alu_op     (d_op),
    .i_alu_inv    (d_inv),
    .i_alu_cin    (d_cin),
    .i_alu_cmp_op (d_cmp),
    .i_alu_lhs    (lhs8),
    .i_alu_rhs    (rhs8),
    .o_alu_res    (res8),
    .o_alu_res_vld(res_vld8),
    .o_alu_cout   (cout8),
    .o_alu_cmp    (cmp8),
    .o_alu_cmp_vld(cmp_vld8)
  );

  int   nchk = 0;
  int   nerr = 0;
  int   pulses16 = 0;
  int   pulses8 = 0;
  out_t got16[$];
  out_t got8[$];
  logic [15:0] sh16 = '0;
  logic [7:0]  sh8 = '0;

  // Assemble words from the last NSLICE result slices; capture one entry per flag pulse.
  initial forever begin
    @(negedge clk);
    if (res_vld16) sh16 = {res16, sh16[15:4]};
    if (cmp_vld16) begin
      got16.push_back('{sh16, cout16, cmp16});
      pulses16++;
    end
    if (res_vld8) sh8 = {res8[0], sh8[7:1]};
    if (cmp_vld8) begin
      got8.push_back('{{8'h00, sh8}, cout8, cmp8});
      pulses8++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] e);
    nchk++;
    if (g !== e) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, g, e);
    end
  endtask

  task automatic check_next(input bit sel, input string nm, input out_t e);
    out_t g;
    int   n;
    n = sel ? got8.size() : got16.size();
    if (n == 0) begin
      nchk++;
      nerr++;
      $display("FAIL %s: no flag pulse seen, expected res=%0h", nm, e.res);
    end else begin
      if (sel) g = got8.pop_front();
      else g = got16.pop_front();
      chk({nm, "_res"}, 32'(g.res), 32'(e.res));
      chk({nm, "_cout"}, 32'(g.cout), 32'(e.cout));
      chk({nm, "_cmp"}, 32'(g.cmp), 32'(e.cmp));
    end
  endtask

  // Word-level reference: compares judged from plain unsigned/signed integer comparisons.
  function automatic out_t model(input int w, input alu_op_t op, input logic inv,
                                 input logic cin, input cmp_op_t cop, input logic [15:0] lhs,
                                 input logic [15:0] rhs);
    out_t    o;
    longint  mask, a, b, bi, t, sa, sb;
    mask = (longint'(1) << w) - 1;
    a    = longint'(lhs) & mask;
    b    = longint'(rhs) & mask;
    bi   = (inv ? ~b : b) & mask;
    sa   = a[w-1] ? a - (mask + 1) : a;
    sb   = b[w-1] ? b - (mask + 1) : b;
    o    = '{16'h0, 1'b0, 1'b0};
    if (cop != CmpNone) begin
      o.res  = 16'((a - b) & mask);
      o.cout = (a >= b);
      case (cop)
        CmpEq:   o.cmp = (a == b);
        CmpNe:   o.cmp = (a != b);
        CmpLt:   o.cmp = (sa < sb);
        CmpLtu:  o.cmp = (a < b);
        CmpGe:   o.cmp = (sa >= sb);
        CmpGeu:  o.cmp = (a >= b);
        default: o.cmp = 1'b0;
      endcase
    end else begin
      case (op)
        AluAdd: begin
          t      = a + bi + longint'(cin);
          o.res  = 16'(t & mask);
          o.cout = t[w];
        end
        AluAnd:  o.res = 16'(a & bi);
        AluOr:   o.res = 16'(a | bi);
        AluXor:  o.res = 16'(a ^ bi);
        AluShl: begin
          o.res  = 16'((a << 1) & mask);
          o.cout = a[w-1];
        end
        default: o.res = 16'h0;
      endcase
    end
    return o;
  endfunction

  // Drives the first nk slices; control inputs carry junk after slice 0.
  task automatic drive_op(input bit sel, input int nk, input alu_op_t op, input logic inv,
                          input logic cin, input cmp_op_t cop, input logic [15:0] lhs,
                          input logic [15:0] rhs);
    for (int k = 0; k < nk; k++) begin
      @(negedge clk);
      if (k == 0) begin
        d_op = op; d_inv = inv; d_cin = cin; d_cmp = cop;
      end else begin
        d_op  = alu_op_t'($urandom_range(0, 4));
        d_inv = 1'($urandom);
        d_cin = 1'($urandom);
        d_cmp = cmp_op_t'($urandom_range(0, 6));
      end
      if (!sel) begin
        vld16 = 1'b1; ctr16 = 2'(k);
        lhs16 = 4'(lhs >> (4 * k)); rhs16 = 4'(rhs >> (4 * k));
      end else begin
        vld8 = 1'b1; ctr8 = 3'(k);
        lhs8 = lhs[k]; rhs8 = rhs[k];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld16 = 1'b0;
      vld8  = 1'b0;
    end
  endtask

  vec_t tbl[14];
  out_t e, e2;
  int   p0;
  alu_op_t ro[2];
  logic    ri[2], rc[2];
  cmp_op_t rk[2];
  logic [15:0] rl[2], rr[2];

  initial begin
    tbl[0]  = '{AluAdd, 1'b0, 1'b0, CmpNone, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0};
    tbl[1]  = '{AluAdd, 1'b0, 1'b0, CmpLtu,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
    tbl[2]  = '{AluAdd, 1'b0, 1'b0, CmpLt,   16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1};
    tbl[3]  = '{AluAdd, 1'b0, 1'b0, CmpEq,   16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
    tbl[4]  = '{AluAdd, 1'b0, 1'b0, CmpLt,   16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    tbl[5]  = '{AluAdd, 1'b0, 1'b0, CmpLtu,  16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0};
    tbl[6]  = '{AluAdd, 1'b0, 1'b0, CmpEq,   16'hBEEF, 16'hBEEF, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{AluShl, 1'b0, 1'b1, CmpNone, 16'h8421, 16'hFFFF, 16'h0842, 1'b1, 1'b0};
    tbl[8]  = '{AluXor, 1'b0, 1'b0, CmpGe,   16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b1};
    tbl[9]  = '{AluAdd, 1'b0, 1'b0, CmpNe,   16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
    tbl[10] = '{AluAdd, 1'b0, 1'b0, CmpGeu,  16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
    tbl[11] = '{AluAnd, 1'b1, 1'b0, CmpNone, 16'hF0F0, 16'hFF00, 16'h00F0, 1'b0, 1'b0};
    tbl[12] = '{AluXor, 1'b0, 1'b0, CmpNone, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b0, 1'b0};
    tbl[13] = '{AluAdd, 1'b1, 1'b1, CmpNone, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0};

    rst_n16 = 1'b0; rst_n8 = 1'b0;
    vld16 = 1'b0; vld8 = 1'b0; ctr16 = '0; ctr8 = '0;
    lhs16 = '0; rhs16 = '0; lhs8 = '0; rhs8 = '0;
    d_op = AluAdd; d_inv = 1'b0; d_cin = 1'b0; d_cmp = CmpNone;
    repeat (3) @(negedge clk);
    chk("rst_res", 32'(res16), 0);
    chk("rst_res_vld", 32'(res_vld16), 0);
    chk("rst_cout", 32'(cout16), 0);
    chk("rst_cmp", 32'(cmp16), 0);
    chk("rst_cmp_vld", 32'(cmp_vld16), 0);
    rst_n16 = 1'b1; rst_n8 = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive_op(0, 4, tbl[i].op, tbl[i].inv, tbl[i].cin, tbl[i].cmp, tbl[i].lhs, tbl[i].rhs);
      idle(2);
      check_next(0, $sformatf("vec%0d", i), '{tbl[i].eres, tbl[i].ecout, tbl[i].ecmp});
    end
    chk("res_hold", 32'(res16), 32'(tbl[13].eres[15:12]));

    // Slice with ctr!=0 while idle must be ignored.
    p0 = pulses16;
    @(negedge clk);
    vld16 = 1'b1; ctr16 = 2'd2; d_op = AluAdd; lhs16 = 4'h5; rhs16 = 4'h5;
    @(negedge clk);
    vld16 = 1'b0;
    chk("idle_ctr_ignored", 32'(res_vld16), 0);
    idle(5);
    chk("idle_no_pulse", pulses16 - p0, 0);

    // Abort after slice 1 leaves a carry pending; the next op must not see it.
    p0 = pulses16;
    drive_op(0, 2, AluAdd, 1'b0, 1'b1, CmpNone, 16'hFFFF, 16'h0001);
    idle(5);
    chk("abort_no_pulse", pulses16 - p0, 0);
    chk("abort_no_result", got16.size(), 0);
    drive_op(0, 4, AluAdd, 1'b0, 1'b0, CmpNone, 16'h0001, 16'h0001);
    idle(2);
    check_next(0, "after_abort", '{16'h0002, 1'b0, 1'b0});

    // Out-of-sequence slice 0 restarts in the same cycle.
    p0 = pulses16;
    drive_op(0, 2, AluAdd, 1'b0, 1'b1, CmpNone, 16'hFFFF, 16'hFFFF);
    drive_op(0, 4, AluAdd, 1'b0, 1'b0, CmpNone, 16'h1111, 16'h2222);
    idle(2);
    chk("restart_pulses", pulses16 - p0, 1);
    check_next(0, "restart", '{16'h3333, 1'b0, 1'b0});

    // Back-to-back with no gap.
    p0 = pulses16;
    drive_op(0, 4, AluAdd, 1'b0, 1'b0, CmpNone, 16'h1234, 16'h0FCD);
    drive_op(0, 4, AluAdd, 1'b0, 1'b1, CmpLtu, 16'hFFFF, 16'h0002);
    idle(2);
    chk("b2b_pulses", pulses16 - p0, 2);
    check_next(0, "b2b_first", '{16'h2201, 1'b0, 1'b0});
    check_next(0, "b2b_second", '{16'hFFFD, 1'b1, 1'b0});

    // Randomized pairs issued back-to-back.
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < 2; j++) begin
        ro[j] = alu_op_t'($urandom_range(0, 4));
        ri[j] = 1'($urandom);
        rc[j] = 1'($urandom);
        rk[j] = ($urandom_range(0, 1) == 0) ? CmpNone : cmp_op_t'($urandom_range(1, 6));
        rl[j] = 16'($urandom);
        rr[j] = ($urandom_range(0, 7) == 0) ? rl[j] : 16'($urandom);
        drive_op(0, 4, ro[j], ri[j], rc[j], rk[j], rl[j], rr[j]);
      end
      idle(2);
      for (int j = 0; j < 2; j++) begin
        e = model(16, ro[j], ri[j], rc[j], rk[j], rl[j], rr[j]);
        check_next(0, $sformatf("rnd16_%0d_%0d", it, j), e);
      end
    end

    // 8-bit, 1-bit slices.
    drive_op(1, 8, AluAdd, 1'b0, 1'b0, CmpNone, 16'h00FF, 16'h0001);
    idle(2);
    check_next(1, "w8_add_ff_01", '{16'h0000, 1'b1, 1'b0});
    for (int it = 0; it < 12; it++) begin
      ro[0] = alu_op_t'($urandom_range(0, 4));
      ri[0] = 1'($urandom);
      rc[0] = 1'($urandom);
      rk[0] = ($urandom_range(0, 1) == 0) ? CmpNone : cmp_op_t'($urandom_range(1, 6));
      rl[0] = 16'($urandom_range(0, 255));
      rr[0] = 16'($urandom_range(0, 255));
      drive_op(1, 8, ro[0], ri[0], rc[0], rk[0], rl[0], rr[0]);
      idle(2);
      e2 = model(8, ro[0], ri[0], rc[0], rk[0], rl[0], rr[0]);
      check_next(1, $sformatf("rnd8_%0d", it), e2);
    end

    // Async reset right after slice 3 is accepted: outputs clear at once, no flag pulse.
    p0 = pulses8;
    drive_op(1, 4, AluAdd, 1'b0, 1'b0, CmpLt, 16'h0008, 16'h0000);
    @(posedge clk);
    #2;
    chk("w8_pre_rst_res_vld", 32'(res_vld8), 1);
    rst_n8 = 1'b0;
    #1;
    chk("w8_rst_res", 32'(res8), 0);
    chk("w8_rst_res_vld", 32'(res_vld8), 0);
    chk("w8_rst_cout", 32'(cout8), 0);
    chk("w8_rst_cmp", 32'(cmp8), 0);
    chk("w8_rst_cmp_vld", 32'(cmp_vld8), 0);
    @(negedge clk);
    vld8 = 1'b0;
    rst_n8 = 1'b1;
    idle(10);
    chk("w8_rst_no_pulse", pulses8 - p0, 0);
    chk("w8_no_stray", got8.size(), 0);
    chk("w16_no_stray", got16.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
